// File: rtl/dma_pkg.sv
// Shared types and helpers for the DMA channel arbiter: state encoding,
// channel-count defaults and one-hot/index conversion.
package dma_pkg;

  localparam int NCH  = 4;
  localparam int CH_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_GRANT   = 3'd2,
    ST_GAP     = 3'd3,
    ST_RELEASE = 3'd4
  } dma_state_e;

  function automatic logic [CH_W-1:0] onehot_to_idx(input logic [NCH-1:0] oh);
    logic [CH_W-1:0] idx;
    idx = {CH_W{1'b0}};
    for (int i = 0; i < NCH; i++) begin
      idx = idx | (oh[i] ? CH_W'(i) : {CH_W{1'b0}});
    end
    return idx;
  endfunction

  function automatic logic [NCH-1:0] idx_to_onehot(input logic [CH_W-1:0] idx);
    logic [NCH-1:0] oh;
    oh = {NCH{1'b0}};
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/dma_prio_pick.sv
// Combinational request picker: first set request found when searching
// upward (with wrap) from start_ptr. A zero pointer gives fixed priority.
module dma_prio_pick
  import dma_pkg::*;
(
  input  logic [NCH-1:0]  req,
  input  logic [CH_W-1:0] start_ptr,
  output logic [NCH-1:0]  winner,
  output logic [CH_W-1:0] idx,
  output logic            any_req
);

  logic            taken_s;
  logic [CH_W-1:0] cand_s;

  // Walk the channels in priority order; the first pending one wins.
  always_comb begin
    winner  = {NCH{1'b0}};
    taken_s = 1'b0;
    cand_s  = start_ptr;
    for (int i = 0; i < NCH; i++) begin
      cand_s         = start_ptr + CH_W'(i);
      winner[cand_s] = req[cand_s] & ~taken_s;
      taken_s        = taken_s | req[cand_s];
    end
  end

  assign idx     = onehot_to_idx(winner);
  assign any_req = |req;

endmodule

// File: rtl/dma_channel_arbiter.sv
// DMA front-end scheduler: HRQ/HLDA bus-hold handshake, per-grant channel
// pick and burst limiting. Define DMA_ROTATING_PRIORITY_EN for round-robin.
module dma_channel_arbiter
  import dma_pkg::*;
#(
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 8
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [NCH-1:0]  DREQ,
  input  logic            HLDA,
  input  logic            XFER_ACK,
  output logic            HRQ,
  output logic [NCH-1:0]  DACK,
  output logic [CH_W-1:0] CH_SEL,
  output logic            GRANT_VLD,
  output logic            ABORT
);

  localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  dma_state_e      state_r, state_s;
  logic            hrq_r, hrq_s;
  logic [NCH-1:0]  dack_r, dack_s;
  logic [CH_W-1:0] ch_sel_r, ch_sel_s;
  logic            gvld_r, gvld_s;
  logic            abort_r, abort_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [CNT_W-1:0] cnt_inc_s, cnt_sat_s;
  logic            burst_done_s;
  logic [CH_W-1:0] ptr_r;
  logic [NCH-1:0]  win_oh_s;
  logic [CH_W-1:0] win_idx_s;
  logic            any_req_s;

  dma_prio_pick u_pick (
    .req       (DREQ),
    .start_ptr (ptr_r),
    .winner    (win_oh_s),
    .idx       (win_idx_s),
    .any_req   (any_req_s)
  );

`ifdef DMA_ROTATING_PRIORITY_EN
  // Last-served channel drops to lowest priority once its grant ends.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ptr_r <= {CH_W{1'b0}};
    end else if (state_r == ST_GRANT && state_s != ST_GRANT) begin
      ptr_r <= ch_sel_r + {{(CH_W-1){1'b0}}, 1'b1};
    end else begin
      ptr_r <= ptr_r;
    end
  end
`else
  assign ptr_r = {CH_W{1'b0}};
`endif

  assign cnt_inc_s    = cnt_r + CNT_ONE;
  assign cnt_sat_s    = (cnt_r >= BURST_LIM) ? cnt_r : cnt_inc_s;
  assign burst_done_s = XFER_ACK && (cnt_inc_s >= BURST_LIM);

  // Next-state and next-output decode; outputs are registered below.
  always_comb begin
    state_s  = state_r;
    hrq_s    = hrq_r;
    dack_s   = dack_r;
    ch_sel_s = ch_sel_r;
    gvld_s   = gvld_r;
    abort_s  = 1'b0;
    cnt_s    = cnt_r;
    case (state_r)
      ST_IDLE: begin
        dack_s = {NCH{1'b0}};
        gvld_s = 1'b0;
        if (any_req_s) begin
          state_s = ST_REQ;
          hrq_s   = 1'b1;
        end else begin
          state_s = ST_IDLE;
          hrq_s   = 1'b0;
        end
      end
      ST_REQ: begin
        hrq_s = 1'b1;
        if (!any_req_s) begin
          state_s = ST_RELEASE;
          hrq_s   = 1'b0;
        end else if (HLDA) begin
          state_s  = ST_GRANT;
          dack_s   = win_oh_s;
          ch_sel_s = win_idx_s;
          gvld_s   = 1'b1;
          cnt_s    = {CNT_W{1'b0}};
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_GRANT: begin
        if (!HLDA) begin
          state_s = ST_RELEASE;
          hrq_s   = 1'b0;
          dack_s  = {NCH{1'b0}};
          gvld_s  = 1'b0;
          abort_s = 1'b1;
        end else begin
          // An ACK in the same cycle as the DREQ drop still counts.
          if (XFER_ACK) begin
            cnt_s = cnt_sat_s;
          end else begin
            cnt_s = cnt_r;
          end
          if (burst_done_s || !DREQ[ch_sel_r]) begin
            state_s = ST_GAP;
            dack_s  = {NCH{1'b0}};
            gvld_s  = 1'b0;
          end else begin
            state_s = ST_GRANT;
          end
        end
      end
      ST_GAP: begin
        cnt_s = {CNT_W{1'b0}};
        if (!HLDA) begin
          state_s = ST_RELEASE;
          hrq_s   = 1'b0;
          abort_s = 1'b1;
        end else if (!any_req_s) begin
          state_s = ST_RELEASE;
          hrq_s   = 1'b0;
        end else begin
          state_s  = ST_GRANT;
          dack_s   = win_oh_s;
          ch_sel_s = win_idx_s;
          gvld_s   = 1'b1;
        end
      end
      ST_RELEASE: begin
        hrq_s  = 1'b0;
        dack_s = {NCH{1'b0}};
        gvld_s = 1'b0;
        if (!HLDA) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RELEASE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        hrq_s   = 1'b0;
        dack_s  = {NCH{1'b0}};
        gvld_s  = 1'b0;
        cnt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, burst counter and output registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r  <= ST_IDLE;
      hrq_r    <= 1'b0;
      dack_r   <= {NCH{1'b0}};
      ch_sel_r <= {CH_W{1'b0}};
      gvld_r   <= 1'b0;
      abort_r  <= 1'b0;
      cnt_r    <= {CNT_W{1'b0}};
    end else begin
      state_r  <= state_s;
      hrq_r    <= hrq_s;
      dack_r   <= dack_s;
      ch_sel_r <= ch_sel_s;
      gvld_r   <= gvld_s;
      abort_r  <= abort_s;
      cnt_r    <= cnt_s;
    end
  end

  assign HRQ       = hrq_r;
  assign DACK      = dack_r;
  assign CH_SEL    = ch_sel_r;
  assign GRANT_VLD = gvld_r;
  assign ABORT     = abort_r;

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Self-checking bench for dma_channel_arbiter: directed scenarios plus a
// randomized run, all compared against a transaction-level bus-hold model.
module tb_dma_channel_arbiter;

  localparam int BL = 4;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [3:0] DREQ;
  logic       HLDA;
  logic       XFER_ACK;
  logic       HRQ;
  logic [3:0] DACK;
  logic [1:0] CH_SEL;
  logic       GRANT_VLD;
  logic       ABORT;

  always #5 CLK = ~CLK;

  dma_channel_arbiter #(.BURST_LEN(BL), .CNT_W(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .DREQ(DREQ), .HLDA(HLDA), .XFER_ACK(XFER_ACK),
    .HRQ(HRQ), .DACK(DACK), .CH_SEL(CH_SEL), .GRANT_VLD(GRANT_VLD), .ABORT(ABORT)
  );

  int nvec = 0;
  int nerr = 0;

  logic [8:0] act;
  assign act = {HRQ, DACK, CH_SEL, GRANT_VLD, ABORT};

  // Reference model: bus ownership described as "asking", "holding channel c
  // with n transfers left", "between bursts", "giving the bus back".
  bit m_asking, m_giving_back, m_between;
  int m_ch, m_left, m_ptr, m_last;
  bit m_abort;

  function automatic int pick_ch(logic [3:0] d, int start);
    int r;
    int c;
    r = -1;
    for (int i = 0; i < 4; i++) begin
      c = (start + i) % 4;
      if (r < 0 && d[c]) r = c;
    end
    return r;
  endfunction

  function automatic void model_reset();
    m_asking = 0; m_giving_back = 0; m_between = 0;
    m_ch = -1; m_left = 0; m_ptr = 0; m_last = 0; m_abort = 0;
  endfunction

  function automatic void give_back(bit aborted);
    if (m_ch >= 0) m_ptr = (m_ch + 1) % 4;
    m_ch = -1; m_asking = 0; m_between = 0; m_giving_back = 1; m_abort = aborted;
  endfunction

  function automatic void model_step(logic [3:0] d, logic h, logic x);
    int start;
    m_abort = 0;
`ifdef DMA_ROTATING_PRIORITY_EN
    start = m_ptr;
`else
    start = 0;
`endif
    if (m_giving_back) begin
      if (!h) m_giving_back = 0;
    end else if (!m_asking) begin
      if (d != 4'b0000) m_asking = 1;
    end else if (m_ch >= 0) begin
      if (!h) give_back(1);
      else begin
        if (x) m_left = m_left - 1;
        if (m_left == 0 || !d[m_ch]) begin
          m_ptr = (m_ch + 1) % 4; m_ch = -1; m_between = 1;
        end
      end
    end else begin
      if (m_between && !h) give_back(1);
      else if (d == 4'b0000) give_back(0);
      else if (h) begin
        m_ch = pick_ch(d, start); m_last = m_ch; m_left = BL; m_between = 0;
      end
    end
  endfunction

  function automatic logic [8:0] exp_outs();
    logic [3:0] dk;
    dk = (m_ch >= 0) ? (4'b0001 << m_ch) : 4'b0000;
    return {m_asking, dk, 2'(m_last), (m_ch >= 0), m_abort};
  endfunction

  task automatic step(input logic [3:0] d, input logic h, input logic x);
    DREQ = d; HLDA = h; XFER_ACK = x;
    @(posedge CLK);
    model_step(d, h, x);
    #1;
  endtask

  task automatic do_reset();
    DREQ = 4'b0000; HLDA = 1'b0; XFER_ACK = 1'b0;
    RST_N = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    nvec++;
    if (act !== 9'b0) begin
      nerr++; $display("FAIL reset_outs: got %b want %b", act, 9'b0);
    end
    step(4'b0000, 1'b0, 1'b0);
    nvec++;
    if (act !== exp_outs()) begin
      nerr++; $display("FAIL reset_idle: got %b want %b", act, exp_outs());
    end
  endtask

  task automatic test_single_channel();
    logic [5:0] seq [10];
    seq = '{ {4'b0010,1'b0,1'b0}, {4'b0010,1'b0,1'b0}, {4'b0010,1'b0,1'b0},
             {4'b0010,1'b1,1'b0}, {4'b0010,1'b1,1'b1}, {4'b0010,1'b1,1'b1},
             {4'b0010,1'b1,1'b1}, {4'b0010,1'b1,1'b1}, {4'b0000,1'b1,1'b0},
             {4'b0000,1'b0,1'b0} };
    for (int i = 0; i < 10; i++) begin
      step(seq[i][5:2], seq[i][1], seq[i][0]);
      nvec++;
      if (act !== exp_outs()) begin
        nerr++; $display("FAIL single_ch step %0d: got %b want %b", i, act, exp_outs());
      end
      if (i == 0) begin
        nvec++;
        if (HRQ !== 1'b1) begin nerr++; $display("FAIL single_hrq: got %b want 1", HRQ); end
      end
      if (i == 3) begin
        nvec++;
        if (DACK !== 4'b0010 || CH_SEL !== 2'd1) begin
          nerr++; $display("FAIL single_grant: got dack %b ch %0d want 0010 ch 1", DACK, CH_SEL);
        end
      end
      if (i == 7) begin
        nvec++;
        if (DACK !== 4'b0000 || HRQ !== 1'b1) begin
          nerr++; $display("FAIL single_gap: got dack %b hrq %b want 0000 1", DACK, HRQ);
        end
      end
      if (i == 8) begin
        nvec++;
        if (HRQ !== 1'b0) begin nerr++; $display("FAIL single_release: got hrq %b want 0", HRQ); end
      end
    end
  endtask

  task automatic test_priority();
    int g0, g2;
    logic [3:0] prev;
    g0 = 0; g2 = 0; prev = 4'b0000;
    step(4'b0101, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      step(4'b0101, 1'b1, (i == 0) ? 1'b0 : 1'($urandom_range(0, 1)));
      nvec++;
      if (act !== exp_outs() || HRQ !== 1'b1) begin
        nerr++; $display("FAIL priority step %0d: got %b want %b", i, act, exp_outs());
      end
      if (prev == 4'b0000 && DACK == 4'b0001) g0++;
      if (prev == 4'b0000 && DACK == 4'b0100) g2++;
      prev = DACK;
    end
    nvec++;
`ifdef DMA_ROTATING_PRIORITY_EN
    if (g2 == 0 || g0 == 0 || (g0 - g2) > 1 || (g2 - g0) > 1) begin
      nerr++; $display("FAIL rotate_share: got ch0 %0d ch2 %0d grants want alternating", g0, g2);
    end
`else
    if (g2 != 0 || g0 == 0) begin
      nerr++; $display("FAIL fixed_starve: got ch0 %0d ch2 %0d grants want ch2 0", g0, g2);
    end
`endif
    while (m_ch >= 0) step(4'b0000, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    nvec++;
    if (act !== exp_outs() || HRQ !== 1'b0) begin
      nerr++; $display("FAIL priority_end: got %b want %b", act, exp_outs());
    end
  endtask

  task automatic test_drop_dreq();
    logic [5:0] seq [11];
    seq = '{ {4'b0010,1'b0,1'b0}, {4'b0010,1'b1,1'b0}, {4'b0010,1'b1,1'b1},
             {4'b0010,1'b1,1'b1}, {4'b1000,1'b1,1'b0}, {4'b1000,1'b1,1'b0},
             {4'b1000,1'b1,1'b1}, {4'b1000,1'b1,1'b1}, {4'b1000,1'b1,1'b1},
             {4'b1000,1'b1,1'b1}, {4'b0000,1'b1,1'b0} };
    for (int i = 0; i < 11; i++) begin
      step(seq[i][5:2], seq[i][1], seq[i][0]);
      nvec++;
      if (act !== exp_outs()) begin
        nerr++; $display("FAIL drop step %0d: got %b want %b", i, act, exp_outs());
      end
      if (i == 4 || i == 9) begin
        nvec++;
        if (DACK !== 4'b0000) begin nerr++; $display("FAIL drop_gap %0d: got %b want 0000", i, DACK); end
      end
      if (i == 8) begin
        nvec++;
        if (DACK !== 4'b1000) begin nerr++; $display("FAIL drop_cnt_reset: got %b want 1000", DACK); end
      end
    end
    step(4'b0000, 1'b0, 1'b0);
  endtask

  task automatic test_abort();
    int pulses;
    pulses = 0;
    step(4'b0001, 1'b0, 1'b0);
    step(4'b0001, 1'b1, 1'b0);
    step(4'b0001, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(4'b0001, 1'b0, 1'b0);
      nvec++;
      if (act !== exp_outs()) begin
        nerr++; $display("FAIL abort step %0d: got %b want %b", i, act, exp_outs());
      end
      if (ABORT === 1'b1) pulses++;
      if (i == 0) begin
        nvec++;
        if (ABORT !== 1'b1 || DACK !== 4'b0000 || HRQ !== 1'b0) begin
          nerr++; $display("FAIL abort_pulse: got abort %b dack %b hrq %b want 1 0000 0", ABORT, DACK, HRQ);
        end
      end
    end
    nvec++;
    if (pulses != 1 || HRQ !== 1'b1) begin
      nerr++; $display("FAIL abort_once: got %0d pulses hrq %b want 1 pulse hrq 1", pulses, HRQ);
    end
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
  endtask

  task automatic test_async_reset();
    step(4'b0001, 1'b0, 1'b0);
    step(4'b0001, 1'b1, 1'b0);
    step(4'b0100, 1'b1, 1'b0);
    step(4'b0100, 1'b1, 1'b0);
    nvec++;
    if (act !== exp_outs()) begin
      nerr++; $display("FAIL arst_pre: got %b want %b", act, exp_outs());
    end
    #3;
    RST_N = 1'b0;
    #1;
    nvec++;
    if (HRQ !== 1'b0 || DACK !== 4'b0000 || GRANT_VLD !== 1'b0) begin
      nerr++; $display("FAIL arst_immediate: got hrq %b dack %b vld %b want 0", HRQ, DACK, GRANT_VLD);
    end
    model_reset();
    DREQ = 4'b0000; HLDA = 1'b0; XFER_ACK = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0101, 1'b0, 1'b0);
    step(4'b0101, 1'b1, 1'b0);
    nvec++;
    if (DACK !== 4'b0001 || act !== exp_outs()) begin
      nerr++; $display("FAIL arst_ptr: got %b want dack 0001 (%b)", act, exp_outs());
    end
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
  endtask

  task automatic test_pulse_no_grant();
    logic [3:0] seen;
    seen = 4'b0000;
    step(4'b0100, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    nvec++;
    if (HRQ !== 1'b0 || act !== exp_outs()) begin
      nerr++; $display("FAIL pulse_release: got %b want %b", act, exp_outs());
    end
    seen = seen | DACK;
    step(4'b0000, 1'b0, 1'b0);
    seen = seen | DACK;
    nvec++;
    if (seen !== 4'b0000 || act !== exp_outs()) begin
      nerr++; $display("FAIL pulse_no_dack: got dack seen %b want 0000", seen);
    end
  endtask

  task automatic test_random();
    logic [3:0] d;
    logic h, x;
    d = 4'b0000; h = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) d = 4'($urandom_range(0, 15));
      if (HRQ) h = ($urandom_range(0, 15) != 0);
      else     h = ($urandom_range(0, 1) == 0) ? 1'b0 : h;
      x = 1'($urandom_range(0, 1));
      step(d, h, x);
      nvec++;
      if (act !== exp_outs()) begin
        nerr++; $display("FAIL random cyc %0d: got %b want %b", i, act, exp_outs());
      end
    end
    for (int i = 0; i < 3; i++) begin
      step(4'b0000, 1'b0, 1'b0);
      nvec++;
      if (act !== exp_outs()) begin
        nerr++; $display("FAIL random_drain %0d: got %b want %b", i, act, exp_outs());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_channel();
    test_priority();
    test_drop_dreq();
    test_abort();
    test_async_reset();
    test_pulse_no_grant();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/dma_channel_arbiter.md
Name: dma_channel_arbiter

Overview:
- Front-end scheduler for the 4-channel DMA engine on the shared 8-bit DB/AB, 4-bit CB bus.
- Collects DREQ[3:0] from peripherals such as the disk IO and keypad, and runs the HRQ/HLDA bus-hold handshake with the CPU.
- Picks one channel per grant and issues one-hot DACK plus the channel index to the engine.
- Bounds each grant to a burst of BURST_LEN byte transfers so no single peripheral can monopolise the bus.

Parameters:
NCH, 4, number of DMA channels (DREQ/DACK width)
CH_W, 2, channel index width (clog2 NCH)
BURST_LEN, 4, max transfers per grant before re-arbitration (1..255)
CNT_W, 8, burst counter width

Ports:
CLK  in  1  system clock, rising edge
RST_N  in  1  asynchronous active-low reset
DREQ  in  NCH  level DMA requests, bit i = channel i
HLDA  in  1  hold acknowledge from CPU
XFER_ACK  in  1  engine pulse: one byte transfer completed for the granted channel
HRQ  out  1  hold request to CPU
DACK  out  NCH  one-hot channel acknowledge; all-zero when no grant
CH_SEL  out  CH_W  index of the granted channel, valid while DACK != 0
GRANT_VLD  out  1  high while DACK != 0
ABORT  out  1  one-cycle pulse when HLDA drops during GRANT or GAP

Behaviour:
- Reset (async, RST_N=0): state IDLE; HRQ=0, DACK=0, CH_SEL=0, GRANT_VLD=0, ABORT=0; burst count=0; rotate pointer=0. Reset mid-grant drops DACK and HRQ immediately, without waiting for a clock edge.
- All outputs are registered. DREQ, HLDA and XFER_ACK are sampled on the CLK rising edge and are synchronous to CLK; no synchronisers.
- IDLE: if DREQ != 0, go to REQ and set HRQ=1 (HRQ visible 1 cycle after DREQ is sampled).
- REQ: hold HRQ=1.
  - HLDA=1 and DREQ != 0: latch the winner, go to GRANT. DACK/CH_SEL/GRANT_VLD are driven the next cycle; burst count=0.
  - DREQ=0 (any HLDA): go to RELEASE.
- GRANT: DACK holds the winner; HRQ stays 1.
  - Each XFER_ACK increments the count.
  - Exit to GAP when an XFER_ACK brings the count to BURST_LEN.
  - Also exit to GAP when DREQ[CH_SEL] is sampled 0. An XFER_ACK in that same cycle is still counted.
  - HLDA=0 overrides both: go to RELEASE, pulse ABORT, and DACK=0 next cycle.
- GAP: one cycle with DACK=0 and HRQ=1, so the engine sees the grant edge.
  - HLDA=1 and DREQ != 0: re-arbitrate and go straight to GRANT. The bus is not released between bursts.
  - DREQ=0: go to RELEASE.
  - HLDA=0: go to RELEASE and pulse ABORT.
- RELEASE: HRQ=0, DACK=0. Stay until HLDA is sampled 0, then go to IDLE. No new HRQ is raised while HLDA is still 1.
- Arbitration: fixed priority, channel 0 highest. Ties are resolved in the sampling cycle only; a DREQ arriving after the grant is latched waits for the next GAP.
- XFER_ACK outside GRANT is ignored.
- BURST_LEN=1 means every transfer is followed by a GAP.
- The count saturates at BURST_LEN and never wraps.

Optional Feature:
- Macro: DMA_ROTATING_PRIORITY_EN.
- Defined: round-robin priority. After a grant to channel k, the search starts at (k+1) mod NCH, so the last-served channel becomes lowest priority. The rotate pointer updates on entry to GAP or RELEASE from GRANT and resets to 0.
- Undefined: fixed priority as above. The pointer logic is not synthesised.

Decomposition:
- Shared package dma_pkg:
  - state encoding typedef: IDLE, REQ, GRANT, GAP, RELEASE
  - NCH and CH_W defaults
  - one-hot/index conversion function
- One sub-module: dma_prio_pick. It is combinational: inputs are the request vector and start pointer; outputs are the one-hot winner, the index, and an any-request flag. Fixed priority ties the pointer to 0.

Test Plan:
- Reset, then DREQ=4'b0010, HLDA driven 2 cycles after HRQ rises → HRQ=1 next cycle; DACK=4'b0010, CH_SEL=1 one cycle after HLDA=1; after 4 XFER_ACK, one GAP cycle with DACK=0; DREQ=0 → HRQ=0, IDLE once HLDA=0.
- DREQ=4'b0101 held, BURST_LEN=4:
  - fixed priority: DACK=0001 repeatedly, channel 2 starves while channel 0 is held;
  - DMA_ROTATING_PRIORITY_EN: grants alternate 0001, 0100, 0001, each 4 ACKs, HRQ never drops.
- Channel 1 drops DREQ after 2 ACKs → GAP; count resets; next grant goes to any pending channel.
- HLDA forced 0 mid-GRANT after 1 ACK → ABORT pulses once; DACK=0 and HRQ=0 next cycle; no re-request until HLDA has been sampled 0.
- RST_N asserted mid-GRANT, asynchronous to CLK → DACK, HRQ and GRANT_VLD go to 0 immediately; after release, state is IDLE and the rotate pointer is 0.
- DREQ pulses high then low before HLDA arrives → REQ then RELEASE; HRQ drops; no DACK is ever asserted.
